// File: rtl/digit_entry_display_if.sv
// Keypad digit strobe bus between the keypad decoder and the entry buffer.
//   key_valid : one-cycle strobe, key_val is meaningful while high
//   key_val   : 4-bit keypad digit code
// master = keypad decoder side (drives), slave = entry buffer side (receives).
interface digit_entry_display_if;
  logic       key_valid;
  logic [3:0] key_val;

  modport master (output key_valid, output key_val);
  modport slave  (input  key_valid, input  key_val);
endinterface

// File: rtl/digit_entry_display.sv
// N-digit entry buffer with debounced next/back/clear buttons and an
// active-low, time-multiplexed anode scan for a seven-segment display.
//   clock, reset : system clock, asynchronous active-high reset
//   key_bus      : keypad digit strobe (slave side)
//   btn_next     : raw button, advance cursor
//   btn_back     : raw button, backspace
//   btn_clear    : raw button, clear buffer
//   anode        : active-low digit enables, slot i -> bit NUM_DIGITS-1-i
//   hex_out      : nibble for the currently lit digit
//   number       : packed buffer, slot i = number[4i+3:4i]
//   cursor       : current write slot, 0..NUM_DIGITS
//   full         : cursor == NUM_DIGITS
module digit_entry_display #(
  parameter int          NUM_DIGITS      = 4,
  parameter int          REFRESH_DIV     = 262144,
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          AUTO_ADVANCE    = 0,
  parameter logic [3:0]  BLANK_CODE      = 4'hF
) (
  input  logic                              clock,
  input  logic                              reset,
  digit_entry_display_if.slave              key_bus,
  input  logic                              btn_next,
  input  logic                              btn_back,
  input  logic                              btn_clear,
  output logic [NUM_DIGITS-1:0]             anode,
  output logic [3:0]                        hex_out,
  output logic [4*NUM_DIGITS-1:0]           number,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   cursor,
  output logic                              full
);
  localparam int CW  = $clog2(NUM_DIGITS + 1);
  localparam int SW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  REF_MAX = RW'(REFRESH_DIV - 1);

  // ---------------- button conditioning ----------------
  // bit 0 = next, bit 1 = back, bit 2 = clear
  logic [2:0] btn_raw;
  logic [2:0] press;
  logic [1:0] fill_reg;
  logic       fill_done;

  assign btn_raw   = {btn_clear, btn_back, btn_next};
  assign fill_done = (fill_reg == 2'd2);

  // Counts the two cycles the synchronisers need to carry real button levels
  // after reset; until then their zeros say nothing about the button.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           fill_reg <= 2'd0;
    else if (!fill_done) fill_reg <= fill_reg + 2'd1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic           s1_reg, s2_reg, deb_reg, deb_prev_reg, armed_reg;
      logic [DBW-1:0] cnt_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          s1_reg       <= 1'b0;
          s2_reg       <= 1'b0;
          deb_reg      <= 1'b0;
          deb_prev_reg <= 1'b0;
          armed_reg    <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          s1_reg       <= btn_raw[gi];
          s2_reg       <= s1_reg;
          deb_prev_reg <= deb_reg;
          if (s2_reg != deb_reg) begin
            if (cnt_reg == DB_MAX) begin
              deb_reg <= s2_reg;
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + DBW'(1);
            end
          end else begin
            cnt_reg <= '0;
          end
          // A button held through reset must be seen released before its
          // next rising edge counts as a press.
          if (fill_done && !s2_reg && !deb_reg) armed_reg <= 1'b1;
        end
      end

      assign press[gi] = deb_reg & ~deb_prev_reg & armed_reg;
    end
  endgenerate

  // ---------------- entry buffer ----------------
  logic [3:0]    slot_reg  [NUM_DIGITS];
  logic [3:0]    slot_next [NUM_DIGITS];
  logic [CW-1:0] cursor_reg, cursor_next, cursor_m1;
  logic [SW-1:0] cur_idx, back_idx;
  logic          at_end, key_ok;

  assign at_end    = (cursor_reg == CW'(NUM_DIGITS));
  assign cursor_m1 = cursor_reg - CW'(1);
  assign cur_idx   = cursor_reg[SW-1:0];
  assign back_idx  = cursor_m1[SW-1:0];
  assign key_ok    = key_bus.key_valid && (key_bus.key_val <= 4'd9) && !at_end;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) slot_next[i] = slot_reg[i];
    cursor_next = cursor_reg;
    if (press[2]) begin
      for (int i = 0; i < NUM_DIGITS; i++) slot_next[i] = BLANK_CODE;
      cursor_next = '0;
    end else if (press[1]) begin
      if (cursor_reg != '0) begin
        cursor_next         = cursor_m1;
        slot_next[back_idx] = BLANK_CODE;
      end else begin
        slot_next[0] = BLANK_CODE;
      end
    end else if (press[0]) begin
      if (!at_end) cursor_next = cursor_reg + CW'(1);
    end else if (key_ok) begin
      slot_next[cur_idx] = key_bus.key_val;
      // key_ok already guarantees cursor < NUM_DIGITS, so no wrap here
      if (AUTO_ADVANCE != 0) cursor_next = cursor_reg + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) slot_reg[i] <= BLANK_CODE;
      cursor_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) slot_reg[i] <= slot_next[i];
      cursor_reg <= cursor_next;
    end
  end

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_pack
      assign number[4*gi +: 4] = slot_reg[gi];
    end
  endgenerate

  assign cursor = cursor_reg;
  assign full   = at_end;

  // ---------------- display scan ----------------
  logic [RW-1:0]         refresh_reg;
  logic [SW-1:0]         scan_reg;
  logic [NUM_DIGITS-1:0] sel_onehot;
  logic [3:0]            sel_val;
  logic [NUM_DIGITS-1:0] anode_reg;
  logic [3:0]            hex_reg;

  assign sel_val = slot_reg[scan_reg];

  // Slot 0 is the leftmost digit, i.e. the most significant anode bit.
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_reg == SW'(i)) sel_onehot[NUM_DIGITS-1-i] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refresh_reg <= '0;
      scan_reg    <= '0;
      anode_reg   <= '1;
      hex_reg     <= BLANK_CODE;
    end else begin
      if (refresh_reg == REF_MAX) begin
        refresh_reg <= '0;
        scan_reg    <= (scan_reg == SW'(NUM_DIGITS - 1)) ? '0 : scan_reg + SW'(1);
      end else begin
        refresh_reg <= refresh_reg + RW'(1);
      end
      // Blank slots light nothing; hex_out keeps the last shown digit.
      if (sel_val == BLANK_CODE) begin
        anode_reg <= '1;
      end else begin
        anode_reg <= ~sel_onehot;
        hex_reg   <= sel_val;
      end
    end
  end

  assign anode   = anode_reg;
  assign hex_out = hex_reg;
endmodule

// File: tb/tb_digit_entry_display.sv
module tb_digit_entry_display;
  logic clock = 1'b0;
  logic reset;
  logic next0, back0, clear0, next1, back1, clear1;
  logic [3:0]  anode0, anode1, hex0, hex1;
  logic [15:0] num0, num1;
  logic [2:0]  cur0, cur1;
  logic        full0, full1;
  int n_cmp = 0;
  int n_bad = 0;

  digit_entry_display_if kb0 ();
  digit_entry_display_if kb1 ();

  always #5 clock = ~clock;

  digit_entry_display #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEBOUNCE_CYCLES(3),
                        .AUTO_ADVANCE(0), .BLANK_CODE(4'hF)) dut (
    .clock(clock), .reset(reset), .key_bus(kb0.slave),
    .btn_next(next0), .btn_back(back0), .btn_clear(clear0),
    .anode(anode0), .hex_out(hex0), .number(num0), .cursor(cur0), .full(full0));

  digit_entry_display #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEBOUNCE_CYCLES(3),
                        .AUTO_ADVANCE(1), .BLANK_CODE(4'hF)) dut_a (
    .clock(clock), .reset(reset), .key_bus(kb1.slave),
    .btn_next(next1), .btn_back(back1), .btn_clear(clear1),
    .anode(anode1), .hex_out(hex1), .number(num1), .cursor(cur1), .full(full1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance n rising edges, land 1 time unit after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_btn(input int d, input int b, input logic v);
    case ({d[0], b[1:0]})
      3'b000: next0  = v;
      3'b001: back0  = v;
      3'b010: clear0 = v;
      3'b100: next1  = v;
      3'b101: back1  = v;
      default: clear1 = v;
    endcase
  endtask

  // clean press: high for 6 cycles (update lands on the 6th edge), low for 8
  task automatic press(input int d, input int b);
    set_btn(d, b, 1'b1);
    tick(6);
    set_btn(d, b, 1'b0);
    tick(8);
  endtask

  task automatic key0(input logic [3:0] v);
    kb0.key_valid = 1'b1; kb0.key_val = v;
    tick(1);
    kb0.key_valid = 1'b0;
  endtask

  task automatic wait_anode0(input string tag, input logic [3:0] want);
    logic found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (anode0 == want) found = 1'b1;
      else tick(1);
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    {next0, back0, clear0, next1, back1, clear1} = '0;
    kb0.key_valid = 1'b0; kb0.key_val = 4'd0;
    kb1.key_valid = 1'b0; kb1.key_val = 4'd0;
    tick(3);
    check("rst_number", {16'd0, num0}, 32'hFFFF);
    check("rst_cursor", {29'd0, cur0}, 32'd0);
    check("rst_full",   {31'd0, full0}, 32'd0);
    check("rst_anode",  {28'd0, anode0}, 32'hF);
    check("rst_hex",    {28'd0, hex0}, 32'hF);
    reset = 1'b0;
    tick(5);

    // key 5, next, key 7
    key0(4'd5);
    check("key5_number", {16'd0, num0}, 32'hFFF5);
    press(0, 0);
    check("next_cursor", {29'd0, cur0}, 32'd1);
    key0(4'd7);
    check("key7_number", {16'd0, num0}, 32'hFF75);
    check("key7_cursor", {29'd0, cur0}, 32'd1);
    check("key7_full",   {31'd0, full0}, 32'd0);
    key0(4'd12);
    check("key12_ignored", {16'd0, num0}, 32'hFF75);

    // scan: 0111/5 x4, 1011/7 x4, then 1111 x8 with hex held at 7
    wait_anode0("scan_sync_blank", 4'b1111);
    wait_anode0("scan_sync_slot0", 4'b0111);
    for (int k = 0; k < 16; k++) begin
      if (k < 4) begin
        check("scan_anode_s0", {28'd0, anode0}, 32'h7);
        check("scan_hex_s0",   {28'd0, hex0}, 32'h5);
      end else if (k < 8) begin
        check("scan_anode_s1", {28'd0, anode0}, 32'hB);
        check("scan_hex_s1",   {28'd0, hex0}, 32'h7);
      end else begin
        check("scan_anode_blank", {28'd0, anode0}, 32'hF);
        check("scan_hex_hold",    {28'd0, hex0}, 32'h7);
      end
      tick(1);
    end

    // auto-advance: 1,2,3,4 fill the buffer, 9 is dropped while full
    kb1.key_valid = 1'b1;
    kb1.key_val = 4'd1; tick(1);
    kb1.key_val = 4'd2; tick(1);
    kb1.key_val = 4'd3; tick(1);
    kb1.key_val = 4'd4; tick(1);
    kb1.key_val = 4'd9; tick(1);
    kb1.key_valid = 1'b0;
    check("auto_number", {16'd0, num1}, 32'h4321);
    check("auto_cursor", {29'd0, cur1}, 32'd4);
    check("auto_full",   {31'd0, full1}, 32'd1);
    press(1, 0);
    check("next_saturate", {29'd0, cur1}, 32'd4);
    press(1, 1);
    check("back1_number", {16'd0, num1}, 32'hF321);
    check("back1_cursor", {29'd0, cur1}, 32'd3);
    press(1, 1);
    check("back2_number", {16'd0, num1}, 32'hFF21);
    check("back2_cursor", {29'd0, cur1}, 32'd2);
    check("back2_full",   {31'd0, full1}, 32'd0);

    // bounces shorter than the debounce window
    for (int k = 0; k < 6; k++) begin
      next0 = 1'b1; tick(1);
      next0 = 1'b0; tick(1);
    end
    tick(6);
    check("bounce_cursor", {29'd0, cur0}, 32'd1);

    // clean 5-cycle press: pulse in cycle 5, cursor moves on the 6th edge
    next0 = 1'b1;
    tick(5);
    check("latency_before", {29'd0, cur0}, 32'd1);
    next0 = 1'b0;
    tick(1);
    check("latency_after", {29'd0, cur0}, 32'd2);
    tick(10);
    check("single_increment", {29'd0, cur0}, 32'd2);

    // clear beats a key strobe in the same cycle
    clear0 = 1'b1;
    tick(5);
    kb0.key_valid = 1'b1; kb0.key_val = 4'd3;
    tick(1);
    kb0.key_valid = 1'b0;
    clear0 = 1'b0;
    check("clear_number", {16'd0, num0}, 32'hFFFF);
    check("clear_cursor", {29'd0, cur0}, 32'd0);
    tick(10);
    check("clear_key_dropped", {16'd0, num0}, 32'hFFFF);

    // backspace at cursor 0 blanks slot 0 and keeps the cursor
    key0(4'd8);
    check("key8_number", {16'd0, num0}, 32'hFFF8);
    press(0, 1);
    check("back0_number", {16'd0, num0}, 32'hFFFF);
    check("back0_cursor", {29'd0, cur0}, 32'd0);

    // reset while back is half-debounced and slot 0 is lit
    key0(4'd2);
    wait_anode0("pre_reset_lit", 4'b0111);
    back0 = 1'b1;
    tick(3);
    check("pre_reset_hex", {28'd0, hex0}, 32'h2);
    reset = 1'b1;
    #1;
    check("midrst_anode",  {28'd0, anode0}, 32'hF);
    check("midrst_hex",    {28'd0, hex0}, 32'hF);
    check("midrst_number", {16'd0, num0}, 32'hFFFF);
    check("midrst_number_a", {16'd0, num1}, 32'hFFFF);
    tick(2);
    reset = 1'b0;
    tick(4);
    key0(4'd6);
    tick(20);
    check("held_no_back", {16'd0, num0}, 32'hFFF6);
    check("held_cursor",  {29'd0, cur0}, 32'd0);
    back0 = 1'b0;
    tick(10);
    press(0, 1);
    check("rearm_back", {16'd0, num0}, 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/digit_entry_display.md
Name: digit_entry_display

Overview:
- Parametrised N-digit entry buffer with a time-multiplexed, active-low anode scan driver for the board's seven-segment display.
- Accepts validated keypad digits, places them at a cursor, and supports debounced next, backspace and clear buttons.
- Blank slots are suppressed on the display.
- Sits between the keypad decoder and the hex-to-segment decoder; the packed buffer is also exported to game logic.

Parameters:
- NUM_DIGITS, 4: number of digit slots and anodes (1..8).
- REFRESH_DIV, 262144: clock cycles each anode stays selected before the scan advances.
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronised cycles required to accept a button level change.
- AUTO_ADVANCE, 0: 1 = cursor advances automatically after a digit write; 0 = cursor moves only on btn_next.
- BLANK_CODE, 4'hF: nibble value that marks an empty slot.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_val is valid.
- key_val  in  4  keypad digit code.
- btn_next  in  1  raw button: advance cursor.
- btn_back  in  1  raw button: backspace.
- btn_clear  in  1  raw button: clear buffer.
- anode  out  NUM_DIGITS  active-low digit enables.
- hex_out  out  4  nibble for the currently selected anode.
- number  out  4*NUM_DIGITS  packed buffer; slot i = number[4i+3:4i].
- cursor  out  $clog2(NUM_DIGITS+1)  current write slot, 0..NUM_DIGITS.
- full  out  1  high when cursor == NUM_DIGITS.

Behaviour:
- Reset values (asynchronous, all registers):
  - number = all BLANK_CODE; cursor = 0; full = 0.
  - anode = all 1; hex_out = BLANK_CODE.
  - Scan index, refresh counter, debounce state and synchronisers = 0.
- Button path, per button, independent:
  - 2-FF synchroniser, then debounce counter.
  - The counter resets whenever the synchronised level differs from the debounced level.
  - When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronised level.
  - A rising edge of the debounced level produces a one-cycle press pulse.
  - Latency: press pulse is asserted DEBOUNCE_CYCLES+2 cycles after a clean raw edge.
  - Bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- Buffer update: at most one action per cycle, priority clear > back > next > key.
  - clear: all slots = BLANK_CODE; cursor = 0.
  - back:
    - If cursor > 0: cursor -= 1, and the slot at the new cursor = BLANK_CODE.
    - If cursor == 0: slot 0 = BLANK_CODE and cursor stays 0.
  - next: cursor += 1, saturating at NUM_DIGITS.
  - key: only when key_valid=1, key_val <= 9 and cursor < NUM_DIGITS.
    - Slot[cursor] = key_val.
    - If AUTO_ADVANCE=1, cursor += 1 in the same cycle.
    - key_val >= 10 is ignored.
    - A key while full is ignored; number is unchanged.
  - Lower-priority events in a cycle where a higher-priority one fires are dropped, not queued.
  - number, cursor and full update on the clock edge after the accepted event.
  - full is combinationally consistent with the registered cursor.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index advances; it wraps from NUM_DIGITS-1 to 0.
  - Slot i drives anode bit (NUM_DIGITS-1-i), so slot 0 is the leftmost digit.
  - anode and hex_out are registered and update the cycle after the scan index changes.
  - If the selected slot == BLANK_CODE: anode = all 1 and hex_out holds its previous value.
  - Otherwise exactly one anode bit is 0 and hex_out = slot value.
  - The scan reflects buffer writes within one cycle.
- Reset mid-operation: all state returns to reset values immediately, including partial debounce counts; a held button must be released and pressed again.
- Widths: the cursor increment must not wrap; saturate explicitly.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, DEBOUNCE_CYCLES=3 unless stated):
- Reset, then key 5, next, key 7 -> number=16'hFF75, cursor=1.
  - The scan shows anode 0111/hex 5 for 4 cycles, then 1011/hex 7.
  - Slots 2 and 3 leave anode=1111.
- AUTO_ADVANCE=1; keys 1,2,3,4,9 -> number=16'h4321, full=1, cursor=4; the fifth key is ignored.
- From number=16'h4321 with cursor=4: back twice -> number=16'hFF21, cursor=2; back at cursor=0 keeps cursor 0 and slot 0 blank.
- btn_next toggling 1-cycle high pulses (shorter than debounce) -> cursor unchanged; a clean 5-cycle press -> exactly one increment, pulse 5 cycles after the raw edge.
- Clear and key_valid in the same cycle -> number=16'hFFFF, cursor=0; the key is dropped.
- Assert reset mid-scan while btn_back is half-debounced -> anode=1111, number=16'hFFFF immediately; no backspace after reset is released while the button is still held.
